// File: rtl/gfx_cmd_queue.sv
// Host-side command FIFO for the graphics core: buffers fill/blit requests and
// sequences them one at a time through the card_busy handshake.
module gfx_cmd_queue #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_start_fill,
  input  logic                     in_start_blit,
  input  logic                     in_fill_value,
  input  logic [8:0]               in_X1,
  input  logic [8:0]               in_X2,
  input  logic [7:0]               in_Y1,
  input  logic [7:0]               in_Y2,
  input  logic [8:0]               in_width,
  input  logic [7:0]               in_height,
  input  logic                     card_busy,
  input  logic                     card_error,
  input  logic                     clr_status,
  output logic                     out_start_fill,
  output logic                     out_start_blit,
  output logic                     out_fill_value,
  output logic [8:0]               out_X1,
  output logic [7:0]               out_Y1,
  output logic [8:0]               out_X2,
  output logic [7:0]               out_Y2,
  output logic [8:0]               out_width,
  output logic [7:0]               out_height,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     q_full,
  output logic                     busy,
  output logic [3:0]               err_flags,
  output logic [7:0]               done_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef struct packed {
    logic       op_blit;
    logic       fill_value;
    logic [8:0] x1;
    logic [7:0] y1;
    logic [8:0] x2;
    logic [7:0] y2;
    logic [8:0] width;
    logic [7:0] height;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  entry_t          mem [DEPTH];
  entry_t          in_entry;
  entry_t          cur;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   ack_cnt;
  state_t          state, state_next;
  logic            pop, push, op_done, timeout_evt;
  logic            req_one, conflict, overflow, card_err_evt, zero_blit;
  logic [3:0]      err_next;

  assign req_one      = in_start_fill ^ in_start_blit;
  assign conflict     = in_start_fill & in_start_blit;
  assign q_full       = (count == CW'(DEPTH));
  assign push         = req_one && (!q_full || pop);
  assign overflow     = req_one && q_full && !pop;
  assign card_err_evt = card_error && (state == WAIT_ACK || state == WAIT_DONE);
  assign zero_blit    = cur.op_blit && (cur.width == 9'd0 || cur.height == 8'd0);
  assign in_entry     = '{in_start_blit, in_fill_value, in_X1, in_Y1, in_X2, in_Y2,
                          in_width, in_height};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    op_done        = 1'b0;
    timeout_evt    = 1'b0;
    out_start_fill = 1'b0;
    out_start_blit = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && !card_busy) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (zero_blit) begin
          op_done    = 1'b1;
          state_next = IDLE;
        end else begin
          out_start_fill = !cur.op_blit;
          out_start_blit = cur.op_blit;
          state_next     = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (card_busy) begin
          state_next = WAIT_DONE;
        end else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          op_done     = 1'b1;
          state_next  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!card_busy) begin
          op_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // An error event in the same cycle as clr_status survives the clear.
  always_comb begin
    err_next = clr_status ? 4'b0000 : err_flags;
    err_next = err_next | {card_err_evt, timeout_evt, conflict, overflow};
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= in_entry;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cur       <= '0;
      ack_cnt   <= '0;
      err_flags <= '0;
      done_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        cur    <= mem[rd_ptr];
      end
      count     <= count + CW'(push) - CW'(pop);
      ack_cnt   <= (state == WAIT_ACK) ? ack_cnt + TW'(1) : '0;
      err_flags <= err_next;
      done_cnt  <= done_cnt + 8'(op_done);
    end
  end

  assign out_fill_value = cur.fill_value;
  assign out_X1         = cur.x1;
  assign out_Y1         = cur.y1;
  assign out_X2         = cur.x2;
  assign out_Y2         = cur.y2;
  assign out_width      = cur.width;
  assign out_height     = cur.height;
  assign q_count        = count;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_gfx_cmd_queue.sv
// Directed bench for gfx_cmd_queue: stimulus pushes expected issues into a
// scoreboard; a monitor compares each start pulse against it.
module tb_gfx_cmd_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_start_fill, in_start_blit, in_fill_value;
  logic [8:0] in_X1, in_X2, in_width;
  logic [7:0] in_Y1, in_Y2, in_height;
  logic       card_busy, card_error, clr_status;
  logic       out_start_fill, out_start_blit, out_fill_value;
  logic [8:0] out_X1, out_X2, out_width;
  logic [7:0] out_Y1, out_Y2, out_height;
  logic [2:0] q_count;
  logic       q_full, busy;
  logic [3:0] err_flags;
  logic [7:0] done_cnt;

  gfx_cmd_queue #(.DEPTH(DEPTH), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .in_start_fill(in_start_fill), .in_start_blit(in_start_blit),
    .in_fill_value(in_fill_value), .in_X1(in_X1), .in_X2(in_X2),
    .in_Y1(in_Y1), .in_Y2(in_Y2), .in_width(in_width), .in_height(in_height),
    .card_busy(card_busy), .card_error(card_error), .clr_status(clr_status),
    .out_start_fill(out_start_fill), .out_start_blit(out_start_blit),
    .out_fill_value(out_fill_value), .out_X1(out_X1), .out_Y1(out_Y1),
    .out_X2(out_X2), .out_Y2(out_Y2), .out_width(out_width), .out_height(out_height),
    .q_count(q_count), .q_full(q_full), .busy(busy),
    .err_flags(err_flags), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [52:0] ops;
    int          exp_cyc;   // -1: issue cycle not checked
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic card_hold    = 1'b0;
  logic card_respond = 1'b1;
  logic err_inject   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [52:0] pack(input logic b, input logic v,
                                       input logic [8:0] x1, input logic [7:0] y1,
                                       input logic [8:0] x2, input logic [7:0] y2,
                                       input logic [8:0] w, input logic [7:0] h);
    return {b, v, x1, y1, x2, y2, w, h};
  endfunction

  task automatic send(input logic b, input logic v,
                      input logic [8:0] x1, input logic [7:0] y1,
                      input logic [8:0] x2, input logic [7:0] y2,
                      input logic [8:0] w, input logic [7:0] h);
    in_start_fill = !b;
    in_start_blit = b;
    in_fill_value = v;
    in_X1 = x1; in_Y1 = y1; in_X2 = x2; in_Y2 = y2;
    in_width = w; in_height = h;
    @(negedge clk);
    in_start_fill = 1'b0;
    in_start_blit = 1'b0;
  endtask

  task automatic expect_issue(input logic [52:0] ops, input int exp_cyc);
    exp_t e;
    e.ops = ops;
    e.exp_cyc = exp_cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy && q_count == 3'd0 && !card_busy) break;
      @(negedge clk);
    end
    check("idle_reached", {63'd0, !busy && q_count == 3'd0 && !card_busy}, 64'd1);
  endtask

  task automatic clear_status();
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    check("err_cleared", {60'd0, err_flags}, 64'd0);
  endtask

  // Card model: busy rises one cycle after a start pulse and stays high for 5 cycles.
  initial begin
    card_busy  = 1'b0;
    card_error = 1'b0;
    forever begin
      @(negedge clk);
      if (card_hold) begin
        card_busy = 1'b1;
      end else if (card_respond && (out_start_fill || out_start_blit)) begin
        @(negedge clk);
        card_busy  = 1'b1;
        card_error = err_inject;
        @(negedge clk);
        card_error = 1'b0;
        repeat (4) @(negedge clk);
        card_busy = 1'b0;
      end else begin
        card_busy = 1'b0;
      end
    end
  end

  // Monitor: every start pulse consumes one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_start_fill || out_start_blit) begin
        check("single_pulse", {63'd0, out_start_fill & out_start_blit}, 64'd0);
        check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("issue_ops", {11'd0, pack(out_start_blit, out_fill_value, out_X1, out_Y1,
                                          out_X2, out_Y2, out_width, out_height)},
                {11'd0, e.ops});
          if (e.exp_cyc >= 0) check("issue_cycle", 64'(cyc), 64'(e.exp_cyc));
          check("card_idle_at_issue", {63'd0, card_busy}, 64'd0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    reset = 1'b1;
    in_start_fill = 1'b1;  // request during reset must be discarded
    in_start_blit = 1'b0;
    in_fill_value = 1'b0;
    in_X1 = '0; in_X2 = '0; in_Y1 = '0; in_Y2 = '0; in_width = '0; in_height = '0;
    clr_status = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_q_count", 64'(q_count), 64'd0);
    check("rst_q_full", {63'd0, q_full}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_err", {60'd0, err_flags}, 64'd0);
    check("rst_done", 64'(done_cnt), 64'd0);
    check("rst_ops", {11'd0, out_X1, out_Y1, out_X2, out_Y2, out_width, out_height,
                      out_fill_value, out_start_fill, out_start_blit}, 64'd0);
    reset = 1'b0;
    in_start_fill = 1'b0;
    @(negedge clk);
    check("post_rst_q_count", 64'(q_count), 64'd0);

    // Single fill with latency check.
    c = cyc;
    expect_issue(pack(1'b0, 1'b1, 9'd10, 8'd20, 9'd100, 8'd50, 9'd0, 8'd0), c + 2);
    send(1'b0, 1'b1, 9'd10, 8'd20, 9'd100, 8'd50, 9'd0, 8'd0);
    wait_idle(100);
    check("fill_done_cnt", 64'(done_cnt), 64'd1);
    check("fill_q_count", 64'(q_count), 64'd0);
    check("ops_hold_x1", 64'(out_X1), 64'd10);

    // Conflict with simultaneous clear: conflict bit wins.
    in_start_fill = 1'b1; in_start_blit = 1'b1; clr_status = 1'b1;
    @(negedge clk);
    in_start_fill = 1'b0; in_start_blit = 1'b0; clr_status = 1'b0;
    check("conflict_q_count", 64'(q_count), 64'd0);
    check("conflict_err", {60'd0, err_flags}, 64'b0010);
    clear_status();

    // Five blits against a busy card: four queued, fifth overflows.
    card_hold = 1'b1;
    repeat (2) @(negedge clk);
    expect_issue(pack(1'b1, 1'b0, 9'd1,   8'd2,  9'd3,   8'd4,  9'd5,   8'd6),  -1);
    expect_issue(pack(1'b1, 1'b1, 9'd300, 8'd7,  9'd11,  8'd99, 9'd64,  8'd32), -1);
    expect_issue(pack(1'b1, 1'b0, 9'd511, 8'd255, 9'd0,  8'd1,  9'd1,   8'd1),  -1);
    expect_issue(pack(1'b1, 1'b1, 9'd42,  8'd43, 9'd44,  8'd45, 9'd46,  8'd47), -1);
    send(1'b1, 1'b0, 9'd1,   8'd2,  9'd3,   8'd4,  9'd5,   8'd6);
    send(1'b1, 1'b1, 9'd300, 8'd7,  9'd11,  8'd99, 9'd64,  8'd32);
    send(1'b1, 1'b0, 9'd511, 8'd255, 9'd0,  8'd1,  9'd1,   8'd1);
    send(1'b1, 1'b1, 9'd42,  8'd43, 9'd44,  8'd45, 9'd46,  8'd47);
    send(1'b1, 1'b0, 9'd77,  8'd78, 9'd79,  8'd80, 9'd81,  8'd82);
    check("ovf_q_count", 64'(q_count), 64'd4);
    check("ovf_q_full", {63'd0, q_full}, 64'd1);
    check("ovf_busy", {63'd0, busy}, 64'd0);
    check("ovf_err", {60'd0, err_flags}, 64'b0001);
    card_hold = 1'b0;
    wait_idle(400);
    check("ovf_done_cnt", 64'(done_cnt), 64'd5);
    check("ovf_err_sticky", {60'd0, err_flags}, 64'b0001);
    clear_status();

    // Ack timeout: card never answers; second fill issues 17 cycles after the first.
    card_respond = 1'b0;
    c = cyc;
    expect_issue(pack(1'b0, 1'b0, 9'd5,  8'd6,  9'd7,  8'd8,  9'd9,  8'd10), c + 2);
    expect_issue(pack(1'b0, 1'b1, 9'd15, 8'd16, 9'd17, 8'd18, 9'd19, 8'd20), c + 19);
    send(1'b0, 1'b0, 9'd5,  8'd6,  9'd7,  8'd8,  9'd9,  8'd10);
    send(1'b0, 1'b1, 9'd15, 8'd16, 9'd17, 8'd18, 9'd19, 8'd20);
    wait_idle(100);
    check("timeout_err", {60'd0, err_flags}, 64'b0100);
    check("timeout_done_cnt", 64'(done_cnt), 64'd7);
    card_respond = 1'b1;
    clear_status();

    // Zero-width blit is skipped; the following fill issues two cycles later.
    err_inject = 1'b1;
    c = cyc;
    expect_issue(pack(1'b0, 1'b1, 9'd200, 8'd100, 9'd210, 8'd110, 9'd3, 8'd4), c + 4);
    send(1'b1, 1'b1, 9'd1, 8'd1, 9'd2, 8'd2, 9'd0, 8'd30);
    send(1'b0, 1'b1, 9'd200, 8'd100, 9'd210, 8'd110, 9'd3, 8'd4);
    wait_idle(100);
    err_inject = 1'b0;
    check("zero_blit_done_cnt", 64'(done_cnt), 64'd9);
    check("card_err_flag", {60'd0, err_flags}, 64'b1000);
    clear_status();

    // Reset in WAIT_DONE with three ops still queued.
    c = cyc;
    expect_issue(pack(1'b0, 1'b0, 9'd50, 8'd51, 9'd52, 8'd53, 9'd54, 8'd55), c + 2);
    send(1'b0, 1'b0, 9'd50, 8'd51, 9'd52, 8'd53, 9'd54, 8'd55);
    send(1'b0, 1'b1, 9'd60, 8'd61, 9'd62, 8'd63, 9'd64, 8'd65);
    send(1'b1, 1'b0, 9'd70, 8'd71, 9'd72, 8'd73, 9'd74, 8'd75);
    send(1'b1, 1'b1, 9'd80, 8'd81, 9'd82, 8'd83, 9'd84, 8'd85);
    for (int i = 0; i < 20; i++) begin
      if (card_busy && busy && q_count == 3'd3) break;
      @(negedge clk);
    end
    check("pre_reset_q_count", 64'(q_count), 64'd3);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_q_count", 64'(q_count), 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_q_full", {63'd0, q_full}, 64'd0);
    check("mid_rst_done", 64'(done_cnt), 64'd0);
    check("mid_rst_ops", {11'd0, out_X1, out_Y1, out_X2, out_Y2, out_width, out_height,
                          out_fill_value, out_start_fill, out_start_blit}, 64'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_idle_q", 64'(q_count), 64'd0);
    check("post_rst_done", 64'(done_cnt), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gfx_cmd_queue.md
GFX_CMD_QUEUE -- requirements
Module: gfx_cmd_queue

Interface
REQ-001 Parameters SHALL be:
  - DEPTH, default 4: queue entries; power of two, 2..16.
  - ACK_TIMEOUT, default 15: maximum cycles to wait for card_busy to rise after an issue.
REQ-002 Ports SHALL be:
  - clk  in  1  single clock for all logic.
  - reset  in  1  synchronous, active-high.
  - in_start_fill  in  1  one-cycle fill request from the host port.
  - in_start_blit  in  1  one-cycle blit request from the host port.
  - in_fill_value  in  1  fill colour.
  - in_X1, in_X2  in  9 each  source/destination X.
  - in_Y1, in_Y2  in  8 each  source/destination Y.
  - in_width  in  9  blit width.
  - in_height  in  8  blit height.
  - card_busy  in  1  graphics core is executing an operation.
  - card_error  in  1  graphics core error indication.
  - clr_status  in  1  one-cycle clear of sticky error flags.
  - out_start_fill  out  1  one-cycle fill start to the graphics core.
  - out_start_blit  out  1  one-cycle blit start to the graphics core.
  - out_fill_value, out_X1, out_Y1, out_X2, out_Y2, out_width, out_height  out  same widths as inputs  operands of the current op.
  - q_count  out  $clog2(DEPTH)+1  entries currently queued.
  - q_full  out  1  q_count == DEPTH.
  - busy  out  1  FSM not in IDLE.
  - err_flags  out  4  sticky flags: [0] overflow, [1] conflict, [2] ack timeout, [3] card error.
  - done_cnt  out  8  completed-op counter, wraps 255 -> 0.

Function
REQ-003 Each entry SHALL store op type (0 = fill, 1 = blit), fill_value, X1, Y1, X2, Y2, width and height (53 bits), captured in the cycle the request is sampled.
REQ-004 A cycle with exactly one of in_start_fill / in_start_blit high and the queue not full SHALL enqueue one entry; q_count increments on the next edge.
REQ-005 Both request inputs high in the same cycle SHALL enqueue nothing and set err_flags[1].
REQ-006 A request while the queue is full and no pop occurs in the same cycle SHALL be dropped and set err_flags[0].
REQ-007 A request while full, in the same cycle as a pop, SHALL be accepted; q_count stays at DEPTH.
REQ-008 The FSM SHALL have states IDLE, ISSUE, WAIT_ACK and WAIT_DONE.
REQ-009 IDLE SHALL go to ISSUE when q_count > 0 and card_busy = 0, popping the head entry into the output operand registers.
REQ-010 In ISSUE, the head entry SHALL be handled as follows:
  - Blit with width 0 or height 0: no start pulse; the op counts as completed; next state IDLE.
  - Otherwise: exactly one of out_start_fill / out_start_blit is high for this single cycle; next state WAIT_ACK.
REQ-011 WAIT_ACK SHALL go to WAIT_DONE when card_busy = 1.
REQ-012 If card_busy has not risen after ACK_TIMEOUT cycles in WAIT_ACK, the FSM SHALL set err_flags[2], count the op as completed, and return to IDLE.
REQ-013 WAIT_DONE SHALL return to IDLE when card_busy = 0, and done_cnt SHALL increment on that transition.
REQ-014 card_error = 1 in WAIT_ACK or WAIT_DONE SHALL set err_flags[3] without altering sequencing.
REQ-015 out_* operands SHALL hold stable from ISSUE until the next pop.
REQ-016 Latency SHALL be: request sampled at edge N with the queue empty, FSM idle and card idle -> start pulse visible during cycle N+2.
REQ-017 Queue order SHALL be strict FIFO; read/write pointers wrap modulo DEPTH.
REQ-018 clr_status SHALL clear all err_flags bits on the next edge; an error event in the same cycle takes priority and leaves its bit set.
REQ-019 busy SHALL equal (state != IDLE).

Reset
REQ-020 reset SHALL, at the next clk edge, take effect regardless of state (including mid-operation):
  - state = IDLE, queue emptied, q_count = 0, q_full = 0.
  - out_start_* = 0, all out_* operands = 0.
  - err_flags = 0, done_cnt = 0, busy = 0.
REQ-021 Requests sampled during reset SHALL be discarded.

Verification
REQ-022 Single fill (X1=10, Y1=20, X2=100, Y2=50, value 1); card raises busy 1 cycle after start for 5 cycles -> one out_start_fill pulse at N+2 with operands exactly as given; done_cnt = 1; q_count returns to 0.
REQ-023 Five back-to-back blits with DEPTH=4 and card busy -> first four accepted, fifth dropped; err_flags = 4'b0001; the four blits issue in order, each only after busy falls.
REQ-024 in_start_fill and in_start_blit high together -> q_count unchanged, err_flags[1] = 1; then clr_status -> err_flags = 0.
REQ-025 card_busy held 0 after issue -> err_flags[2] set after 15 WAIT_ACK cycles; FSM back in IDLE; the next queued op issues.
REQ-026 Blit with width 0 queued ahead of a fill -> no blit pulse; fill pulse follows; done_cnt = 2.
REQ-027 reset asserted during WAIT_DONE with 3 ops queued -> next cycle q_count = 0, busy = 0, no further start pulses.
